collatz_datapath: RTL

- Datapath that pairs with the Collatz sequencing controller.
- Consumes the controller's WEN/SEL/FS[1:0] each cycle and returns the status bits One and X0 that the controller branches on.
- Holds the working value X, a temporary register T, a saturating step counter and a sticky overflow flag.
- Exposes X, the step count and the flags to the display/top level.

---
 rtl/collatz_pkg.sv | 19 +
 rtl/collatz_alu.sv | 43 ++++
 rtl/collatz_datapath.sv | 84 ++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared encodings for the Collatz datapath.
// FS selects the ALU operation; SEL chooses between loading a new start value
// and executing the ALU operation requested by the controller.
package collatz_pkg;

    localparam logic [1:0] FS_HALF  = 2'b00;   // X >> 1
    localparam logic [1:0] FS_ADD   = 2'b01;   // X + T
    localparam logic [1:0] FS_DBL   = 2'b10;   // X << 1
    localparam logic [1:0] FS_INC   = 2'b11;   // X + 1

    localparam logic       SEL_LOAD = 1'b0;
    localparam logic       SEL_RUN  = 1'b1;

    // True for the operations that finish a Collatz step when written to X.
    function automatic logic counts_step(input logic [1:0] fs);
        return (fs == FS_HALF) || (fs == FS_INC);
    endfunction

endpackage

// File: rtl/collatz_alu.sv
// Combinational ALU for the Collatz datapath.
// Ports:
//   x, t   : W-bit operands (working value and temporary)
//   fs     : operation select (see collatz_pkg)
//   result : W+1-bit result; bit W is the carry-out used for overflow
module collatz_alu
    import collatz_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] t,
    input  logic [1:0]   fs,
    output logic [W:0]   result
);

    logic [W:0] half_v;
    logic [W:0] dbl_v;

    // Shifts built bitwise so the carry-out placement is explicit: halving
    // never carries, doubling carries out the old MSB.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shift
            assign half_v[gi]  = (gi == W - 1) ? 1'b0 : x[gi + 1];
            assign dbl_v[gi+1] = x[gi];
        end
    endgenerate
    assign half_v[W] = 1'b0;
    assign dbl_v[0]  = 1'b0;

    always_comb begin
        result = '0;
        unique case (fs)
            FS_HALF: result = half_v;
            FS_ADD:  result = {1'b0, x} + {1'b0, t};
            FS_DBL:  result = dbl_v;
            FS_INC:  result = {1'b0, x} + (W + 1)'(1);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/collatz_datapath.sv
// Collatz datapath: holds X, T, a saturating step counter and a sticky
// overflow flag, and returns the One/X0 status bits to the controller.
// Ports:
//   CLK, resetn  : clock and synchronous active-low reset
//   SEL          : 0 = load X_in, 1 = execute FS
//   WEN          : when running, 1 writes the ALU result to T, 0 to X
//   FS           : ALU function select
//   X_in         : start value captured on load
//   X_out        : current X
//   One, X0      : combinational status (X == 1, X[0])
//   STEPS        : completed Collatz steps, saturating
//   OVF          : sticky carry-loss flag, cleared by reset or load
module collatz_datapath
    import collatz_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          SEL,
    input  logic          WEN,
    input  logic [1:0]    FS,
    input  logic [W-1:0]  X_in,
    output logic [W-1:0]  X_out,
    output logic          One,
    output logic          X0,
    output logic [CW-1:0] STEPS,
    output logic          OVF
);

    localparam logic [CW-1:0] STEPS_MAX = {CW{1'b1}};

    logic [W-1:0]  x_reg;
    logic [W-1:0]  t_reg;
    logic [CW-1:0] steps_reg;
    logic          ovf_reg;
    logic [W:0]    alu_result;
    logic          one_flag;

    collatz_alu #(.W(W)) u_alu (
        .x      (x_reg),
        .t      (t_reg),
        .fs     (FS),
        .result (alu_result)
    );

    assign one_flag = (x_reg == W'(1));

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            x_reg     <= '0;
            t_reg     <= '0;
            steps_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (SEL == SEL_LOAD) begin
            x_reg     <= X_in;
            t_reg     <= '0;
            steps_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (!one_flag) begin
            // Once X reaches 1 everything freezes so the result stays
            // visible while the controller idles in its done state.
            if (WEN) begin
                t_reg <= alu_result[W-1:0];
            end else begin
                x_reg <= alu_result[W-1:0];
                if (counts_step(FS) && (steps_reg != STEPS_MAX)) begin
                    steps_reg <= steps_reg + CW'(1);
                end
            end
            if (alu_result[W]) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign X_out = x_reg;
    assign One   = one_flag;
    assign X0    = x_reg[0];
    assign STEPS = steps_reg;
    assign OVF   = ovf_reg;

endmodule
